// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall scheduler for the 5-stage RV32I core.
// Resolves load-use hazards, EX-stage redirects and data-memory wait states
// into stall/flush/freeze controls, and keeps saturating performance counters.
module hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             mem_fault,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic            fault_q;
    logic            load_use;
    logic            mem_stall;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // A RUN-state access that is not completed this cycle starts a wait.
    assign mem_stall = dmem_req && !dmem_ready;

    assign ctrl_state = state;
    assign mem_fault  = fault_q;

    // Zero-latency controls; priority HALT > memory wait > redirect > load-use.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        pipe_freeze = 1'b1;
                    end else if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_stall = 1'b1;
                    end
                end
                default: pipe_freeze = 1'b1;
            endcase
        end
    end

    // Control FSM: wait-cycle counting, timeout detection and sticky fault.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready || !dmem_req) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT_V) begin
                        state   <= HALT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    // Saturating counters; a cycle counts once no matter how many causes apply.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if ((pc_stall || pipe_freeze) && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (idex_flush && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with a queue-based scoreboard.
// The driver pushes the hand-computed expectation for each cycle it drives; a
// monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    // Control vector order: pc_stall ifid_stall ifid_flush idex_stall idex_flush pipe_freeze mem_fault
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1101000;
    localparam logic [6:0] C_RD   = 7'b0010100;
    localparam logic [6:0] C_FRZ  = 7'b0000010;
    localparam logic [6:0] C_FZF  = 7'b0000011;

    typedef struct packed {
        logic [15:0] idx;
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [3:0]  sc;
        logic [3:0]  fc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic             ex_redirect = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic             pipe_freeze, mem_fault;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_count, flush_count;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   vec_idx = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush),
        .pipe_freeze(pipe_freeze), .mem_fault(mem_fault),
        .ctrl_state(ctrl_state), .stall_count(stall_count), .flush_count(flush_count)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue its expectation.
    task automatic applyStimulus(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                                 input logic redir, input logic req, input logic rdy,
                                 input logic [6:0] ctl, input logic [1:0] st, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd; ex_redirect = redir; dmem_req = req; dmem_ready = rdy;
        e.idx = 16'(vec_idx);
        e.ctl = ctl;
        e.st  = st;
        e.sc  = 4'(sc);
        e.fc  = 4'(fc);
        exp_q.push_back(e);
        vec_idx++;
    endtask

    // Quiet cycle: no hazards, no memory traffic.
    task automatic idle(input logic [6:0] ctl, input logic [1:0] st, input int sc, input int fc);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ctl, st, sc, fc);
    endtask

    // Reset cycle whose outputs are not checked (state still settling).
    task automatic holdReset();
        @(posedge clk);
        #1;
        reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0] act;
        act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, pipe_freeze, mem_fault};
        total++;
        if (act !== e.ctl) begin
            bad++;
            $display("[TB] FAIL ctl vec=%0d actual=%b required=%b", e.idx, act, e.ctl);
        end
        total++;
        if (ctrl_state !== e.st) begin
            bad++;
            $display("[TB] FAIL state vec=%0d actual=%b required=%b", e.idx, ctrl_state, e.st);
        end
        total++;
        if (stall_count !== e.sc) begin
            bad++;
            $display("[TB] FAIL stall_count vec=%0d actual=%0d required=%0d", e.idx, stall_count, e.sc);
        end
        total++;
        if (flush_count !== e.fc) begin
            bad++;
            $display("[TB] FAIL flush_count vec=%0d actual=%0d required=%0d", e.idx, flush_count, e.fc);
        end
        total++;
        if (idex_stall === 1'b1 && idex_flush === 1'b1) begin
            bad++;
            $display("[TB] FAIL idex_exclusive vec=%0d actual=11 required=not both", e.idx);
        end
    endtask

    // Monitor: compare one queued expectation per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    // Directed stimulus sequence.
    initial begin
        holdReset();
        holdReset();
        // Reset state
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 0, 0);
        idle(C_NONE, 2'b00, 0, 0);
        // Load x5 in EX, ID reads rs1=x5
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU, 2'b00, 0, 0);
        idle(C_NONE, 2'b00, 1, 0);
        // Load to x0; then a match on rs1 that the instruction does not read
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 1, 0);
        applyStimulus(1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 1, 0);
        // Hit through rs2
        applyStimulus(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_LU, 2'b00, 1, 0);
        // Redirect wins over a concurrent load-use hit
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_RD, 2'b00, 2, 0);
        idle(C_NONE, 2'b00, 2, 1);
        // Three wait cycles then ready: four freeze cycles
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 2, 1);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b01, 3, 1);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b01, 4, 1);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_FRZ, 2'b01, 5, 1);
        // Single-cycle access: no stall
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NONE, 2'b00, 6, 1);
        // Memory wait beats redirect and load-use; dropped request releases
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_FRZ, 2'b00, 6, 1);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_FRZ, 2'b01, 7, 1);
        idle(C_NONE, 2'b00, 8, 1);
        // Timeout of 4: five freeze cycles then HALT with sticky fault
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 8, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b01, 9 + i, 1);
        idle(C_FZF, 2'b10, 13, 1);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_FZF, 2'b10, 14, 1);
        idle(C_FZF, 2'b10, 15, 1);
        idle(C_FZF, 2'b10, 15, 1);
        // Reset leaves HALT
        holdReset();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 0, 0);
        idle(C_NONE, 2'b00, 0, 0);
        // Twenty load-use stalls saturate the 4-bit counter
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, C_LU, 2'b00,
                          (i > 15) ? 15 : i, 0);
        idle(C_NONE, 2'b00, 15, 0);
        // Reset dropped in the middle of a memory wait
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 15, 0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_NONE, 2'b01, 15, 0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NONE, 2'b00, 0, 0);
        idle(C_NONE, 2'b00, 0, 0);
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain actual=%0d pending required=0 pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
